ita_lsu_initiator: RTL and testbench
====================================

// Module: ita_lsu_initiator
// PURPOSE
//  LSU-side master for the interrupt-agent register window (msip, mtime, mtimeh, mtimecmp, mtimecmph).
//  Takes one load/store at a time from the EXU over a valid/ready request channel and checks address and size.
//  Drives the intagent access port (wr/rd/addr/wdata/valid), captures rdata on ready and returns a response with an error flag.
//  Sits between lsu_ctrl and intagent. A hung or illegal access gives a bus error, never a core stall.
// PARAMETERS
//  BASE_ADDR   32'h1000_0000  byte address of register 0 (msip); regs are word-spaced
//  NUM_REGS    5              number of mapped 32-bit registers (offsets 0x00..0x10)
//  TMO_CYCLES  16             cycles to wait for ita_i_exu_ready before a timeout error (>=2)
// PORTS
//  clk              in   1   CPU internal clock
//  rst_n            in   1   asynchronous active-low reset
//  req_valid        in   1   EXU load/store request valid
//  req_ready        out  1   initiator can accept a request
//  req_wr           in   1   1 = store, 0 = load
//  req_addr         in   32  byte address
//  req_wdata        in   32  store data
//  req_size         in   2   0 = byte, 1 = half, 2 = word, 3 = reserved
//  resp_valid       out  1   response valid
//  resp_ready       in   1   EXU accepts the response
//  resp_rdata       out  32  load data (0 for stores and errors)
//  resp_err         out  1   access error (misaligned, unmapped, bad size, timeout)
//  ita_o_exu_valid  out  1   access strobe to intagent
//  ita_o_exu_wr     out  1   write strobe
//  ita_o_exu_rd     out  1   read strobe
//  ita_o_exu_addr   out  32  register address
//  ita_o_exu_wdata  out  32  write data
//  ita_i_exu_rdata  in   32  intagent read data
//  ita_i_exu_ready  in   1   intagent accepts the access (may be combinational from valid)
// BEHAVIOUR
//  - One clock, asynchronous active-low reset (clk, rst_n).
//  - Reset: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0.
//    Reset also gives ita_o_exu_valid/wr/rd=0, addr=0, wdata=0 and timeout counter=0.
//    Reset asserted mid-access aborts the access immediately; no response is produced.
//  - FSM states: IDLE, ACCESS, RESP.
//  - IDLE: req_ready=1. A request is accepted when req_valid & req_ready.
//    Checks on accept:
//      illegal = (req_size!=2) | (req_addr[1:0]!=0)
//                | (req_addr < BASE_ADDR) | (req_addr >= BASE_ADDR+4*NUM_REGS).
//    If illegal: go to RESP with resp_err=1, resp_rdata=0. No ita_o_* activity.
//    If legal: register addr/wdata/wr and go to ACCESS.
//  - ACCESS: ita_o_exu_valid=1. ita_o_exu_wr=req_wr and ita_o_exu_rd=~req_wr, both registered.
//    Address and data are held stable. req_ready=0.
//    If ita_i_exu_ready is high: capture rdata (0 for stores), resp_err=0, go to RESP.
//    Else increment the counter. When counter == TMO_CYCLES-1 with no ready: resp_err=1, resp_rdata=0, go to RESP.
//    All ita_o_* strobes drop to 0 on leaving ACCESS. Only ready-handshake cycles count as an access.
//  - RESP: resp_valid=1, with resp_rdata and resp_err held stable. req_ready=0.
//    On resp_ready go to IDLE and clear the counter.
//  - Latency, legal access with a zero-wait responder:
//    accept in cycle N, strobe in cycle N+1, resp_valid in N+2. Min request-to-request is 3 cycles.
//  - Illegal access: accept in N, resp_valid in N+1.
//  - Counter width is $clog2(TMO_CYCLES)+1. It must not wrap and is cleared whenever IDLE is entered.
//  - req_valid is ignored while not in IDLE, so no second request is queued.
//    A response held under backpressure keeps its data indefinitely.
//  - Store write strobe: exactly one cycle at the intagent when ready is combinational.
// TESTING
//  1. Store 0x1 to 0x1000_0000 (word), tie ready=valid, resp_ready=1
//     -> one-cycle wr strobe in N+1; resp_valid in N+2, err=0; intagent msip becomes 1.
//  2. Load 0x1000_000C after reset
//     -> resp_rdata=32'h1000_0000 (mtimecmp reset value), err=0, resp_valid in N+2.
//  3. Load 0x1000_0002 (misaligned), 0x1000_0014 (unmapped), size=1 at 0x1000_0000
//     -> each gives err=1, rdata=0, resp_valid in N+1, ita_o_exu_valid never asserted.
//  4. Hold ita_i_exu_ready=0, load 0x1000_0004
//     -> valid stays high 16 cycles, then err=1; strobe drops; IDLE after resp_ready.
//  5. Hold resp_ready=0 for 10 cycles after a load
//     -> resp_valid/rdata stable, req_ready=0, req_valid pulses ignored; IDLE one cycle after resp_ready.
//  6. Assert rst_n=0 during ACCESS
//     -> all outputs return to reset values asynchronously; no response after release.

Source files
------------

// File: rtl/ita_lsu_initiator_if.sv
// Signal bundle between the EXU, the LSU initiator and the interrupt-agent register window.
// master = the initiator's view; slave = the EXU/intagent side driving the opposite directions.
interface ita_lsu_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        ita_o_exu_valid;
    logic        ita_o_exu_wr;
    logic        ita_o_exu_rd;
    logic [31:0] ita_o_exu_addr;
    logic [31:0] ita_o_exu_wdata;
    logic [31:0] ita_i_exu_rdata;
    logic        ita_i_exu_ready;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata, req_size,
        input  resp_ready, ita_i_exu_rdata, ita_i_exu_ready,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output ita_o_exu_valid, ita_o_exu_wr, ita_o_exu_rd, ita_o_exu_addr, ita_o_exu_wdata
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata, req_size,
        output resp_ready, ita_i_exu_rdata, ita_i_exu_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  ita_o_exu_valid, ita_o_exu_wr, ita_o_exu_rd, ita_o_exu_addr, ita_o_exu_wdata
    );
endinterface

// File: rtl/ita_lsu_initiator.sv
// LSU-side master for the interrupt-agent register window: one load/store at a time,
// address/size checking, bounded wait on the intagent and an error response instead of a stall.
//
//  state  | meaning
//  IDLE   | req_ready=1, waiting for a request
//  ACCESS | strobe held at the intagent until ready or timeout
//  RESP   | response presented until resp_ready
module ita_lsu_initiator #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          NUM_REGS   = 5,
    parameter int          TMO_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    ita_lsu_initiator_if.master bus
);
    localparam int              CW       = $clog2(TMO_CYCLES) + 1;
    localparam logic [32:0]     END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * NUM_REGS);
    localparam logic [CW-1:0]   TMO_LAST = CW'(TMO_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          wr_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic          accept;
    logic          illegal;

    assign accept  = (state_q == S_IDLE) && bus.req_valid;
    assign illegal = (bus.req_size != 2'd2) || (bus.req_addr[1:0] != 2'b00) ||
                     (bus.req_addr < BASE_ADDR) || ({1'b0, bus.req_addr} >= END_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = illegal ? S_RESP : S_ACCESS;
            S_ACCESS: if (bus.ita_i_exu_ready || (cnt_q == TMO_LAST)) state_d = S_RESP;
            S_RESP:   if (bus.resp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Access context and response payload; the counter saturates at TMO_LAST by leaving ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (accept) begin
                        rdata_q <= '0;
                        err_q   <= illegal;
                        if (!illegal) begin
                            wr_q    <= bus.req_wr;
                            addr_q  <= bus.req_addr;
                            wdata_q <= bus.req_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    if (bus.ita_i_exu_ready) begin
                        rdata_q <= wr_q ? 32'h0 : bus.ita_i_exu_rdata;
                        err_q   <= 1'b0;
                    end else if (cnt_q == TMO_LAST) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: if (bus.resp_ready) cnt_q <= '0;
                default: cnt_q <= '0;
            endcase
        end
    end

    always_comb begin
        bus.req_ready       = 1'b0;
        bus.resp_valid      = 1'b0;
        bus.ita_o_exu_valid = 1'b0;
        bus.ita_o_exu_wr    = 1'b0;
        bus.ita_o_exu_rd    = 1'b0;
        case (state_q)
            S_IDLE:   bus.req_ready = 1'b1;
            S_ACCESS: begin
                bus.ita_o_exu_valid = 1'b1;
                bus.ita_o_exu_wr    = wr_q;
                bus.ita_o_exu_rd    = ~wr_q;
            end
            S_RESP:   bus.resp_valid = 1'b1;
            default:  bus.req_ready = 1'b0;
        endcase
    end

    assign bus.ita_o_exu_addr  = addr_q;
    assign bus.ita_o_exu_wdata = wdata_q;
    assign bus.resp_rdata      = rdata_q;
    assign bus.resp_err        = err_q;
endmodule

// File: tb/tb_ita_lsu_initiator.sv
// Scoreboard bench for ita_lsu_initiator: a register-window responder with programmable wait,
// a reference register map predicting each response, and a monitor checking every handshake.
module tb_ita_lsu_initiator;
    localparam logic [31:0] BASE = 32'h1000_0000;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cur_wait = 0;
    int   vcnt;
    exp_t exp_q[$];

    logic [31:0] model_mem [5];
    logic [31:0] rsp_mem [5];
    logic [31:0] rsp_rdata;

    ita_lsu_initiator_if bus ();

    ita_lsu_initiator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Responder: ready comes combinationally once valid has been waiting cur_wait cycles.
    assign bus.ita_i_exu_ready = bus.ita_o_exu_valid && (vcnt == cur_wait);

    always_comb begin
        logic [31:0] off;
        off = bus.ita_o_exu_addr - BASE;
        rsp_rdata = 32'hDEAD_BEEF;
        if (off < 32'd20) rsp_rdata = rsp_mem[off[4:2]];
    end
    assign bus.ita_i_exu_rdata = rsp_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vcnt <= 0;
        end else begin
            if (!bus.ita_o_exu_valid)       vcnt <= 0;
            else if (!bus.ita_i_exu_ready)  vcnt <= vcnt + 1;
            if (bus.ita_o_exu_valid && bus.ita_i_exu_ready && bus.ita_o_exu_wr &&
                (bus.ita_o_exu_addr - BASE) < 32'd20)
                rsp_mem[3'((bus.ita_o_exu_addr - BASE) >> 2)] <= bus.ita_o_exu_wdata;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_resp: got rdata %0h err %0b expected none",
                         bus.resp_rdata, bus.resp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_rdata", 64'(bus.resp_rdata), 64'(e.rdata));
                check("resp_err", 64'(bus.resp_err), 64'(e.err));
            end
        end
    end

    // Reference: the legality rules, the 16-cycle wait budget and a plain register array.
    task automatic predict(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input int w,
                           output exp_t e, output int lat, output int vc, output int hs);
        longint a;
        a = longint'(addr);
        if (size != 2 || addr[1:0] != 0 || a < longint'(BASE) || a >= longint'(BASE) + 20) begin
            e.err = 1'b1; e.rdata = '0; lat = 1; vc = 0; hs = 0;
        end else if (w >= 16) begin
            e.err = 1'b1; e.rdata = '0; lat = 17; vc = 16; hs = 0;
        end else begin
            int idx;
            idx = int'((a - longint'(BASE)) / 4);
            e.err = 1'b0; lat = w + 2; vc = w + 1; hs = 1;
            if (wr) begin
                model_mem[idx] = wdata;
                e.rdata = '0;
            end else begin
                e.rdata = model_mem[idx];
            end
        end
    endtask

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input int w, input int bp);
        exp_t        e;
        int          e_lat, e_vc, e_hs;
        int          lat, vc, hs, bad;
        logic [31:0] h_rd;
        logic        h_err;
        predict(wr, addr, wdata, size, w, e, e_lat, e_vc, e_hs);
        cur_wait       = w;
        bus.req_wr     = wr;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_size   = size;
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_wr    = ~wr;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        lat = 0; vc = 0; hs = 0; bad = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.ita_o_exu_valid) begin
                vc++;
                if (bus.ita_o_exu_wr !== wr || bus.ita_o_exu_rd !== !wr ||
                    bus.ita_o_exu_addr !== addr || (wr && bus.ita_o_exu_wdata !== wdata)) bad++;
                if (bus.ita_i_exu_ready) hs++;
            end
            if (bus.resp_valid) break;
        end
        check("latency", 64'(lat), 64'(e_lat));
        check("strobe_cycles", 64'(vc), 64'(e_vc));
        check("handshakes", 64'(hs), 64'(e_hs));
        check("strobe_attr", 64'(bad), 64'(0));
        h_rd  = bus.resp_rdata;
        h_err = bus.resp_err;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            bus.req_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("bp_hold", {bus.resp_valid, bus.req_ready, bus.resp_err, bus.resp_rdata},
                  {1'b1, 1'b0, h_err, h_rd});
        end
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        check("back_to_idle", {bus.req_ready, bus.resp_valid}, 2'b10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        model_mem = '{32'h0, 32'h0, 32'h0, 32'h1000_0000, 32'h0};
        rsp_mem   = '{32'h0, 32'h0, 32'h0, 32'h1000_0000, 32'h0};
        bus.req_valid  = 1'b0;
        bus.req_wr     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_size   = 2'd2;
        bus.resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {bus.req_ready, bus.resp_valid, bus.resp_err, bus.ita_o_exu_valid,
                                bus.ita_o_exu_wr, bus.ita_o_exu_rd}, 6'b100000);
        check("reset_data", {bus.resp_rdata, bus.ita_o_exu_addr}, 64'h0);
        check("reset_wdata", 64'(bus.ita_o_exu_wdata), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b0, BASE + 32'hC, 32'h0, 2'd2, 0, 0);
        issue(1'b1, BASE, 32'h1, 2'd2, 0, 0);
        check("msip_written", 64'(rsp_mem[0]), 64'h1);
        issue(1'b0, BASE, 32'h0, 2'd2, 0, 0);
        issue(1'b0, BASE + 32'h2, 32'h0, 2'd2, 0, 0);
        issue(1'b0, BASE + 32'h14, 32'h0, 2'd2, 0, 0);
        issue(1'b0, BASE, 32'h0, 2'd1, 0, 0);
        issue(1'b0, BASE - 32'h4, 32'h0, 2'd2, 0, 0);
        issue(1'b0, BASE + 32'h4, 32'h0, 2'd2, 30, 0);
        issue(1'b1, BASE + 32'h10, 32'hCAFE_F00D, 2'd2, 15, 0);
        issue(1'b0, BASE + 32'h10, 32'h0, 2'd2, 2, 10);

        for (int t = 0; t < 150; t++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            int          w, r;
            case ($urandom_range(0, 9))
                0:       a = BASE - 32'(4 * $urandom_range(1, 4));
                1:       a = BASE + 32'h14;
                2:       a = BASE + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(1, 3));
                3:       a = $urandom;
                default: a = BASE + 32'(4 * $urandom_range(0, 4));
            endcase
            sz = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
            r  = $urandom_range(0, 19);
            if (r < 14)      w = r % 4;
            else if (r < 16) w = 15;
            else             w = 16 + r % 3;
            issue(1'($urandom_range(0, 1)), a, $urandom, sz, w, $urandom_range(0, 3));
        end

        // Reset in the middle of an access: outputs clear at once and no response follows.
        cur_wait       = 30;
        bus.req_wr     = 1'b0;
        bus.req_addr   = BASE + 32'h4;
        bus.req_size   = 2'd2;
        bus.req_valid  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("in_access", 64'(bus.ita_o_exu_valid), 64'h1);
        rst_n = 1'b0;
        #1;
        check("async_reset_ctl", {bus.req_ready, bus.resp_valid, bus.resp_err, bus.ita_o_exu_valid,
                                  bus.ita_o_exu_wr, bus.ita_o_exu_rd}, 6'b100000);
        check("async_reset_data", {bus.resp_rdata, bus.ita_o_exu_addr}, 64'h0);
        check("async_reset_wdata", 64'(bus.ita_o_exu_wdata), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.resp_ready = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.resp_valid || bus.ita_o_exu_valid || !bus.req_ready) seen++;
        end
        check("quiet_after_reset", 64'(seen), 64'h0);
        bus.resp_ready = 1'b0;
        issue(1'b0, BASE + 32'h10, 32'h0, 2'd2, 1, 1);
        check("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
